color_cycle_ctrl: RTL and testbench

Sequencer for the 12-bit color cycle counter that feeds the widget color inputs. It generates that counter's one-clock enable pulse, synchronised to VGA frame boundaries (vsync falling edge). It supports continuous run at a programmable frame divider, single-step on request, and counted bursts. It sits between the VGA timing generator and the color counter; its cycle_en drives the counter's enable directly.

---
 rtl/color_cycle_ctrl.sv | 145 ++++++++++++++
 tb/tb_color_cycle_ctrl.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/color_cycle_ctrl.sv
// Frame-synchronous enable sequencer for the color cycle counter.
// Produces one-clock cycle_en pulses on vsync falling edges in RUN, STEP and counted BURST modes.
module color_cycle_ctrl #(
   parameter int DIV_W   = 4,
   parameter int BURST_W = 8
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               vsync,
   input  logic [1:0]         mode,
   input  logic [DIV_W-1:0]   rate,
   input  logic               step_req,
   input  logic               start,
   input  logic [BURST_W-1:0] burst_len,
   output logic               cycle_en,
   output logic               busy,
   output logic               done,
   output logic [BURST_W-1:0] steps_left
);

   localparam logic [1:0] M_OFF   = 2'b00;
   localparam logic [1:0] M_RUN   = 2'b01;
   localparam logic [1:0] M_STEP  = 2'b10;
   localparam logic [1:0] M_BURST = 2'b11;

   // BURST is the active burst; the burst-idle sub-state is IDLE with mode=BURST
   typedef enum logic [1:0] {IDLE, RUN, STEP, BURST} state_t;

   state_t             state, state_nxt;
   logic               vsync_q;
   logic [1:0]         mode_q;
   logic [DIV_W-1:0]   div_cnt, div_nxt;
   logic               pending, pending_nxt;
   logic               cycle_en_nxt, busy_nxt, done_nxt;
   logic [BURST_W-1:0] steps_nxt;
   logic               tick, mode_chg, div_hit;

   assign tick     = vsync_q & ~vsync;
   assign mode_chg = (mode != mode_q);
   assign div_hit  = (div_cnt == rate);

   // mode_q resets to OFF so any non-OFF mode after reset is seen as a change
   // and enters its state with a cleared divider.
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         vsync_q    <= 1'b1;
         mode_q     <= M_OFF;
         div_cnt    <= '0;
         pending    <= 1'b0;
         cycle_en   <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         steps_left <= '0;
      end else begin
         state      <= state_nxt;
         vsync_q    <= vsync;
         mode_q     <= mode;
         div_cnt    <= div_nxt;
         pending    <= pending_nxt;
         cycle_en   <= cycle_en_nxt;
         busy       <= busy_nxt;
         done       <= done_nxt;
         steps_left <= steps_nxt;
      end
   end

   always_comb begin
      state_nxt    = state;
      div_nxt      = div_cnt;
      pending_nxt  = pending;
      cycle_en_nxt = 1'b0;
      busy_nxt     = busy;
      done_nxt     = 1'b0;
      steps_nxt    = steps_left;

      if (mode_chg) begin
         // abort whatever was in flight; no pulse and no done on a mode change
         div_nxt     = '0;
         pending_nxt = 1'b0;
         busy_nxt    = 1'b0;
         steps_nxt   = '0;
         case (mode)
            M_RUN:   state_nxt = RUN;
            M_STEP:  state_nxt = STEP;
            default: state_nxt = IDLE;
         endcase
      end else begin
         unique case (state)
            IDLE: begin
               if (mode == M_BURST && start) begin
                  if (burst_len == '0) begin
                     done_nxt = 1'b1;
                  end else begin
                     steps_nxt = burst_len;
                     div_nxt   = '0;
                     busy_nxt  = 1'b1;
                     state_nxt = BURST;
                  end
               end
            end
            RUN: begin
               if (tick) begin
                  if (div_hit) begin
                     cycle_en_nxt = 1'b1;
                     div_nxt      = '0;
                  end else begin
                     div_nxt = div_cnt + 1'b1;
                  end
               end
            end
            STEP: begin
               // a request landing on a tick only arms the following tick
               if (tick && pending) begin
                  cycle_en_nxt = 1'b1;
                  pending_nxt  = 1'b0;
                  busy_nxt     = 1'b0;
               end else if (step_req && !pending) begin
                  pending_nxt = 1'b1;
                  busy_nxt    = 1'b1;
               end
            end
            BURST: begin
               if (tick) begin
                  if (div_hit) begin
                     div_nxt = '0;
                     if (steps_left != '0) begin
                        cycle_en_nxt = 1'b1;
                        steps_nxt    = steps_left - 1'b1;
                     end
                     if (steps_left <= BURST_W'(1)) begin
                        done_nxt  = 1'b1;
                        busy_nxt  = 1'b0;
                        state_nxt = IDLE;
                     end
                  end else begin
                     div_nxt = div_cnt + 1'b1;
                  end
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_color_cycle_ctrl.sv
// Self-checking bench for color_cycle_ctrl: frame-count reference model checked every cycle,
// directed scenarios with literal expectations, then randomized mode/frame/request traffic.
module tb_color_cycle_ctrl;
   localparam int DIV_W   = 4;
   localparam int BURST_W = 8;
   localparam logic [1:0] MD_OFF = 2'b00, MD_RUN = 2'b01, MD_STEP = 2'b10, MD_BURST = 2'b11;

   logic               clk = 1'b0;
   logic               reset = 1'b1;
   logic               vsync = 1'b1;
   logic [1:0]         mode = MD_OFF;
   logic [DIV_W-1:0]   rate = '0;
   logic               step_req = 1'b0;
   logic               start = 1'b0;
   logic [BURST_W-1:0] burst_len = '0;
   logic               cycle_en, busy, done;
   logic [BURST_W-1:0] steps_left;

   int n_chk = 0, n_fail = 0;
   int en_cnt = 0, done_cnt = 0, wide_cnt = 0, coinc_cnt = 0;
   logic en_prev = 1'b0;

   // reference model: ticks counted since the last divider restart, one armed
   // step request, and the number of burst steps still owed
   bit         m_vs = 1'b1;
   logic [1:0] m_mode = MD_OFF;
   int         m_ticks = 0, m_left = 0;
   bit         m_armed = 1'b0;
   bit         e_en = 1'b0, e_done = 1'b0, e_busy = 1'b0;
   int         e_left = 0;

   color_cycle_ctrl #(.DIV_W(DIV_W), .BURST_W(BURST_W)) dut (
      .clk(clk), .reset(reset), .vsync(vsync), .mode(mode), .rate(rate),
      .step_req(step_req), .start(start), .burst_len(burst_len),
      .cycle_en(cycle_en), .busy(busy), .done(done), .steps_left(steps_left)
   );

   initial forever #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, n_chk=%0d", n_chk);
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_step();
      bit tk;
      e_en   = 1'b0;
      e_done = 1'b0;
      if (reset) begin
         m_vs = 1'b1; m_mode = MD_OFF; m_ticks = 0; m_left = 0; m_armed = 1'b0;
      end else begin
         tk   = m_vs && !vsync;
         m_vs = vsync;
         if (mode != m_mode) begin
            m_mode = mode; m_ticks = 0; m_left = 0; m_armed = 1'b0;
         end else begin
            case (mode)
               MD_RUN: if (tk) begin
                  m_ticks++;
                  if (m_ticks % (int'(rate) + 1) == 0) e_en = 1'b1;
               end
               MD_STEP: begin
                  if (tk && m_armed) begin
                     e_en = 1'b1; m_armed = 1'b0;
                  end else if (step_req) m_armed = 1'b1;
               end
               MD_BURST: begin
                  if (m_left == 0) begin
                     if (start) begin
                        if (burst_len == 0) e_done = 1'b1;
                        else begin m_left = int'(burst_len); m_ticks = 0; end
                     end
                  end else if (tk) begin
                     m_ticks++;
                     if (m_ticks % (int'(rate) + 1) == 0) begin
                        e_en = 1'b1;
                        m_left--;
                        if (m_left == 0) e_done = 1'b1;
                     end
                  end
               end
               default: ;
            endcase
         end
      end
      e_left = m_left;
      e_busy = (m_mode == MD_STEP) ? m_armed : ((m_mode == MD_BURST) ? (m_left != 0) : 1'b0);
   endtask

   // compare process: model advances on every edge, DUT is sampled 1ns later
   initial forever begin
      @(posedge clk);
      model_step();
      #1;
      chk("cycle_en", cycle_en, e_en);
      chk("busy", busy, e_busy);
      chk("done", done, e_done);
      chk("steps_left", steps_left, e_left);
      if (cycle_en) en_cnt++;
      if (done) done_cnt++;
      if (cycle_en && en_prev) wide_cnt++;
      if (cycle_en && done) coinc_cnt++;
      en_prev = cycle_en;
   end

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   // one frame: vsync low for a single cycle (the tick), then high for hi cycles
   task automatic tick_frame(input int hi);
      vsync = 1'b0; cyc(1);
      vsync = 1'b1; cyc(hi);
   endtask

   initial begin
      int e0, d0, c0;
      int ph, fl, lo, len;
      logic [1:0] nm;

      // reset state
      cyc(3);
      chk("reset_outputs", {cycle_en, busy, done, steps_left}, 0);
      reset = 1'b0;
      cyc(2);

      // 1: RUN rate=2, 9 frames -> 3 one-cycle pulses
      mode = MD_RUN; rate = 2; cyc(3);
      e0 = en_cnt;
      repeat (9) tick_frame(6);
      chk("t1_pulses", en_cnt - e0, 3);
      chk("t1_width", wide_cnt, 0);

      // 2: STEP, three requests between ticks -> one pulse at next tick only
      mode = MD_STEP; cyc(3);
      tick_frame(6);
      e0 = en_cnt;
      repeat (3) begin step_req = 1'b1; cyc(1); step_req = 1'b0; cyc(1); end
      chk("t2_busy_armed", busy, 1);
      tick_frame(6);
      chk("t2_one_pulse", en_cnt - e0, 1);
      chk("t2_busy_clear", busy, 0);
      tick_frame(6);
      chk("t2_no_extra", en_cnt - e0, 1);

      // 3: BURST rate=0 len=4, start mid-burst ignored
      mode = MD_BURST; rate = 0; cyc(3);
      e0 = en_cnt; d0 = done_cnt; c0 = coinc_cnt;
      burst_len = 4; start = 1'b1; cyc(1); start = 1'b0;
      chk("t3_loaded", steps_left, 4);
      chk("t3_busy", busy, 1);
      tick_frame(6);
      chk("t3_after1", steps_left, 3);
      burst_len = 9; start = 1'b1; cyc(1); start = 1'b0;
      chk("t3_restart_ignored", steps_left, 3);
      repeat (3) tick_frame(6);
      chk("t3_steps_zero", steps_left, 0);
      chk("t3_pulses", en_cnt - e0, 4);
      chk("t3_done_once", done_cnt - d0, 1);
      chk("t3_done_with_en", coinc_cnt - c0, 1);
      chk("t3_busy_end", busy, 0);

      // 4: zero-length burst -> done next cycle, no pulses
      e0 = en_cnt; d0 = done_cnt;
      burst_len = 0; start = 1'b1; cyc(1); start = 1'b0;
      chk("t4_done_next", done, 1);
      chk("t4_busy", busy, 0);
      repeat (3) tick_frame(6);
      chk("t4_no_pulses", en_cnt - e0, 0);
      chk("t4_done_once", done_cnt - d0, 1);

      // 5: abort burst with steps_left=5 by switching to OFF
      burst_len = 8; start = 1'b1; cyc(1); start = 1'b0;
      repeat (3) tick_frame(6);
      chk("t5_mid", steps_left, 5);
      e0 = en_cnt; d0 = done_cnt;
      mode = MD_OFF; cyc(1);
      chk("t5_steps_cleared", steps_left, 0);
      chk("t5_busy_cleared", busy, 0);
      repeat (2) tick_frame(6);
      chk("t5_no_pulses", en_cnt - e0, 0);
      chk("t5_no_done", done_cnt - d0, 0);

      // 6: reset on a tick during RUN, divider restarts from 0
      mode = MD_RUN; rate = 1; cyc(3);
      tick_frame(6);
      vsync = 1'b0; reset = 1'b1; cyc(1);
      reset = 1'b0; vsync = 1'b1;
      chk("t6_after_reset", {cycle_en, busy, done, steps_left}, 0);
      cyc(5);
      e0 = en_cnt;
      tick_frame(6);
      chk("t6_first_tick", en_cnt - e0, 0);
      tick_frame(6);
      chk("t6_second_tick", en_cnt - e0, 1);

      // randomized traffic; rate only changes together with a mode change
      ph = 0; fl = 6; lo = 1;
      for (int s = 0; s < 250; s++) begin
         nm = 2'($urandom_range(0, 3));
         if (nm != mode) rate = DIV_W'($urandom_range(0, 3));
         mode = nm;
         len = $urandom_range(30, 150);
         for (int c = 0; c < len; c++) begin
            vsync     = (ph < lo) ? 1'b0 : 1'b1;
            ph++;
            if (ph >= fl) begin
               ph = 0; fl = $urandom_range(3, 10); lo = $urandom_range(1, 2);
            end
            step_req  = ($urandom_range(0, 5) == 0);
            start     = ($urandom_range(0, 7) == 0);
            burst_len = BURST_W'($urandom_range(0, 5));
            reset     = ($urandom_range(0, 299) == 0);
            cyc(1);
         end
      end
      reset = 1'b0; step_req = 1'b0; start = 1'b0; vsync = 1'b1;
      cyc(2);
      chk("never_wide", wide_cnt, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
